// File: rtl/fetch_unit.sv
// lx32 instruction-fetch stage: owns the PC, issues in-order imem requests and buffers
// {pc, instr} for decode; execute redirects flush the buffer and discard wrong-path fetches.

module fetch_unit_checker #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = 2
) (
   input logic             clk,
   input logic             rst_n,
   input logic             redirect,
   input logic             req_valid,
   input logic             req_ready,
   input logic [WIDTH-1:0] req_addr,
   input logic             rsp_valid,
   input logic [CW-1:0]    outstanding
);
   rsp_has_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      rsp_valid |-> (outstanding != '0));

   req_held_until_ready: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid && !req_ready && !redirect) |=> (req_valid && $stable(req_addr)));
endmodule

module fetch_unit #(
   parameter int unsigned       WIDTH    = 32,
   parameter logic [WIDTH-1:0]  RESET_PC = {WIDTH{1'b0}},
   parameter int unsigned       DEPTH    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] redirect_pc_i,
   output logic             imem_req_valid_o,
   input  logic             imem_req_ready_i,
   output logic [WIDTH-1:0] imem_req_addr_o,
   input  logic             imem_rsp_valid_i,
   input  logic [31:0]      imem_rsp_data_i,
   output logic             if_valid_o,
   input  logic             if_ready_i,
   output logic [WIDTH-1:0] if_pc_o,
   output logic [31:0]      if_instr_o
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t           state_r, state_nxt_s;
   logic [WIDTH-1:0] pc_r, pc_nxt_s;
   logic [CW-1:0]    outstanding_r, outstanding_nxt_s;
   logic [CW-1:0]    drop_r, drop_nxt_s;
   logic [CW-1:0]    count_r, count_nxt_s;
   logic [PW-1:0]    head_r, head_nxt_s, tail_r, tail_nxt_s;
   logic [PW-1:0]    pq_head_r, pq_head_nxt_s, pq_tail_r, pq_tail_nxt_s;
   logic [WIDTH-1:0] pq_r        [DEPTH];
   logic [WIDTH-1:0] buf_pc_r    [DEPTH];
   logic [31:0]      buf_instr_r [DEPTH];
   logic [CW:0]      credit_use_s;
   logic             req_valid_s, hs_s, rsp_s, pop_s, push_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Handshake decode and next value of every control register.
   always_comb begin
      credit_use_s  = {1'b0, outstanding_r} + {1'b0, count_r};
      req_valid_s   = (state_r == RUN) && (credit_use_s < (CW + 1)'(DEPTH));
      hs_s          = req_valid_s && imem_req_ready_i;
      rsp_s         = imem_rsp_valid_i;
      pop_s         = (count_r != '0) && if_ready_i;
      push_s        = rsp_s && !redirect_i && (drop_r == '0);
      state_nxt_s   = state_r;
      pc_nxt_s      = pc_r;
      drop_nxt_s    = drop_r;
      count_nxt_s   = count_r;
      head_nxt_s    = head_r;
      tail_nxt_s    = tail_r;
      pq_head_nxt_s = pq_head_r;
      pq_tail_nxt_s = pq_tail_r;

      if (hs_s && !rsp_s) begin
         outstanding_nxt_s = outstanding_r + CW'(1);
      end else if (!hs_s && rsp_s) begin
         outstanding_nxt_s = outstanding_r - CW'(1);
      end else begin
         outstanding_nxt_s = outstanding_r;
      end

      // Stale responses still pop the pc queue so it stays aligned with memory order.
      if (hs_s) begin
         pq_tail_nxt_s = ptr_inc(pq_tail_r);
      end else begin
         pq_tail_nxt_s = pq_tail_r;
      end
      if (rsp_s) begin
         pq_head_nxt_s = ptr_inc(pq_head_r);
      end else begin
         pq_head_nxt_s = pq_head_r;
      end

      if (redirect_i) begin
         pc_nxt_s    = redirect_pc_i & {{(WIDTH - 2){1'b1}}, 2'b00};
         drop_nxt_s  = outstanding_nxt_s;
         count_nxt_s = '0;
         head_nxt_s  = '0;
         tail_nxt_s  = '0;
      end else begin
         if (hs_s) begin
            pc_nxt_s = pc_r + WIDTH'(32'd4);
         end else begin
            pc_nxt_s = pc_r;
         end
         if (rsp_s && (drop_r != '0)) begin
            drop_nxt_s = drop_r - CW'(1);
         end else begin
            drop_nxt_s = drop_r;
         end
         if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
         end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CW'(1);
         end else begin
            count_nxt_s = count_r;
         end
         if (push_s) begin
            tail_nxt_s = ptr_inc(tail_r);
         end else begin
            tail_nxt_s = tail_r;
         end
         if (pop_s) begin
            head_nxt_s = ptr_inc(head_r);
         end else begin
            head_nxt_s = head_r;
         end
      end

      case (state_r)
         IDLE: state_nxt_s = RUN;
         RUN: begin
            if (redirect_i && (outstanding_nxt_s != '0)) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (drop_nxt_s == '0) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         pc_r          <= RESET_PC;
         outstanding_r <= '0;
         drop_r        <= '0;
         count_r       <= '0;
         head_r        <= '0;
         tail_r        <= '0;
         pq_head_r     <= '0;
         pq_tail_r     <= '0;
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         outstanding_r <= outstanding_nxt_s;
         drop_r        <= drop_nxt_s;
         count_r       <= count_nxt_s;
         head_r        <= head_nxt_s;
         tail_r        <= tail_nxt_s;
         pq_head_r     <= pq_head_nxt_s;
         pq_tail_r     <= pq_tail_nxt_s;
      end
   end

   // Pc queue of in-flight requests and the decode-side instruction buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pq_r[i]        <= '0;
            buf_pc_r[i]    <= '0;
            buf_instr_r[i] <= 32'h0000_0000;
         end
      end else begin
         if (hs_s) begin
            pq_r[pq_tail_r] <= pc_r;
         end
         if (push_s) begin
            buf_pc_r[tail_r]    <= pq_r[pq_head_r];
            buf_instr_r[tail_r] <= imem_rsp_data_i;
         end
      end
   end

   assign imem_req_valid_o = req_valid_s;
   assign imem_req_addr_o  = pc_r;
   assign if_valid_o       = (count_r != '0);
   assign if_pc_o          = if_valid_o ? buf_pc_r[head_r] : '0;
   assign if_instr_o       = if_valid_o ? buf_instr_r[head_r] : 32'h0000_0000;

   fetch_unit_checker #(.WIDTH(WIDTH), .CW(CW)) u_checker (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect_i),
      .req_valid   (req_valid_s),
      .req_ready   (imem_req_ready_i),
      .req_addr    (pc_r),
      .rsp_valid   (imem_rsp_valid_i),
      .outstanding (outstanding_r)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFFC) each fed by an
// in-order imem model with programmable latency; handshakes are logged and compared to tables.

module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect    [2];
   logic [31:0] redirect_pc [2];
   logic        req_valid   [2];
   logic        req_ready   [2];
   logic [31:0] req_addr    [2];
   logic        rsp_valid   [2];
   logic [31:0] rsp_data    [2];
   logic        if_valid    [2];
   logic        if_ready    [2];
   logic [31:0] if_pc       [2];
   logic [31:0] if_instr    [2];
   int          lat         [2];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] req_q0[$], req_q1[$], dec_pc0[$], dec_in0[$], dec_pc1[$];
   bit          found;

   localparam logic [31:0] T2_PC [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
   localparam logic [31:0] T2_IN [4] = '{32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_0008, 32'hDEAD_000C};

   always #5 clk = ~clk;

   fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .redirect_i(redirect[0]), .redirect_pc_i(redirect_pc[0]),
      .imem_req_valid_o(req_valid[0]), .imem_req_ready_i(req_ready[0]), .imem_req_addr_o(req_addr[0]),
      .imem_rsp_valid_i(rsp_valid[0]), .imem_rsp_data_i(rsp_data[0]),
      .if_valid_o(if_valid[0]), .if_ready_i(if_ready[0]), .if_pc_o(if_pc[0]), .if_instr_o(if_instr[0]));

   fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .redirect_i(redirect[1]), .redirect_pc_i(redirect_pc[1]),
      .imem_req_valid_o(req_valid[1]), .imem_req_ready_i(req_ready[1]), .imem_req_addr_o(req_addr[1]),
      .imem_rsp_valid_i(rsp_valid[1]), .imem_rsp_data_i(rsp_data[1]),
      .if_valid_o(if_valid[1]), .if_ready_i(if_ready[1]), .if_pc_o(if_pc[1]), .if_instr_o(if_instr[1]));

   for (genvar g = 0; g < 2; g++) begin : g_mem
      logic [31:0] mq_addr [$];
      int          mq_due  [$];
      int          cyc = 0;

      // Accept requests and retire the response the DUT consumed at this edge.
      always @(posedge clk) begin
         if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
         end else begin
            if (rsp_valid[g] && (mq_addr.size() != 0)) begin
               void'(mq_addr.pop_front());
               void'(mq_due.pop_front());
            end
            if (req_valid[g] && req_ready[g]) begin
               mq_addr.push_back(req_addr[g]);
               mq_due.push_back(cyc + lat[g]);
            end
         end
         cyc <= cyc + 1;
      end

      // Present the oldest response once its latency has elapsed; instr = addr ^ 0xDEAD0000.
      always @(negedge clk) begin
         if (rst_n && (mq_addr.size() != 0) && (mq_due[0] <= cyc)) begin
            rsp_valid[g] <= 1'b1;
            rsp_data[g]  <= mq_addr[0] ^ 32'hDEAD_0000;
         end else begin
            rsp_valid[g] <= 1'b0;
            rsp_data[g]  <= 32'h0000_0000;
         end
      end
   end

   // Log request and decode handshakes as they complete.
   always @(posedge clk) begin
      if (rst_n) begin
         if (req_valid[0] && req_ready[0]) req_q0.push_back(req_addr[0]);
         if (req_valid[1] && req_ready[1]) req_q1.push_back(req_addr[1]);
         if (if_valid[0] && if_ready[0]) begin
            dec_pc0.push_back(if_pc[0]);
            dec_in0.push_back(if_instr[0]);
         end
         if (if_valid[1] && if_ready[1]) dec_pc1.push_back(if_pc[1]);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic clear_logs();
      req_q0.delete(); req_q1.delete();
      dec_pc0.delete(); dec_in0.delete(); dec_pc1.delete();
   endtask

   task automatic do_reset(input int l0, input logic r0, input int l1);
      @(negedge clk);
      rst_n = 1'b0;
      lat[0] = l0; if_ready[0] = r0; lat[1] = l1; if_ready[1] = 1'b1;
      repeat (2) @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
   endtask

   // which: 0 dec_pc0, 1 dec_pc1, 2 req_q0, 3 req_q1
   task automatic wait_for(input string tag, input int which, input int n);
      int got;
      got = 0;
      for (int i = 0; i < 200; i++) begin
         case (which)
            0: got = dec_pc0.size();
            1: got = dec_pc1.size();
            2: got = req_q0.size();
            default: got = req_q1.size();
         endcase
         if (got >= n) break;
         @(negedge clk);
      end
      check_eq(tag, 64'(got >= n), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         redirect[g] = 1'b0; redirect_pc[g] = 32'h0; req_ready[g] = 1'b1;
         if_ready[g] = 1'b1; lat[g] = 1;
      end
      repeat (2) @(negedge clk);
      check_eq("rst_req_valid", 64'(req_valid[0]), 64'd0);
      check_eq("rst_if_valid", 64'(if_valid[0]), 64'd0);
      check_eq("rst_if_pc", 64'(if_pc[0]), 64'd0);
      check_eq("rst_if_instr", 64'(if_instr[0]), 64'd0);
      check_eq("rst_pc1", 64'(req_addr[1]), 64'hFFFF_FFFC);

      // Streaming, latency 1, decode always ready.
      clear_logs();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("t2_first_valid", 64'(req_valid[0]), 64'd1);
      check_eq("t2_first_addr", 64'(req_addr[0]), 64'h0);
      wait_for("t2_wait", 0, 4);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t2_pc%0d", i), 64'(dec_pc0[i]), 64'(T2_PC[i]));
         check_eq($sformatf("t2_in%0d", i), 64'(dec_in0[i]), 64'(T2_IN[i]));
      end

      // Reset mid-stream with fetches in flight.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("t1_req_valid", 64'(req_valid[0]), 64'd0);
      check_eq("t1_if_valid", 64'(if_valid[0]), 64'd0);
      check_eq("t1_if_pc", 64'(if_pc[0]), 64'd0);
      check_eq("t1_if_instr", 64'(if_instr[0]), 64'd0);
      lat[0] = 3;
      repeat (2) @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
      wait_for("t1_wait", 0, 2);
      check_eq("t1_req0", 64'(req_q0[0]), 64'h0);
      check_eq("t1_dec0", 64'(dec_pc0[0]), 64'h0);
      check_eq("t1_in0", 64'(dec_in0[0]), 64'hDEAD_0000);
      check_eq("t1_dec1", 64'(dec_pc0[1]), 64'h4);

      // Decode stalled: buffer fills with DEPTH fetches, then resumes in order.
      do_reset(1, 1'b0, 1);
      repeat (10) @(negedge clk);
      check_eq("t3_req_cnt", 64'(req_q0.size()), 64'd2);
      check_eq("t3_req_valid", 64'(req_valid[0]), 64'd0);
      check_eq("t3_head", 64'(if_pc[0]), 64'h0);
      if_ready[0] = 1'b1;
      wait_for("t3_wait", 0, 3);
      check_eq("t3_dec0", 64'(dec_pc0[0]), 64'h0);
      check_eq("t3_dec1", 64'(dec_pc0[1]), 64'h4);
      check_eq("t3_dec2", 64'(dec_pc0[2]), 64'h8);
      check_eq("t3_req2", 64'(req_q0[2]), 64'h8);

      // Redirect with two requests in flight at latency 3.
      do_reset(3, 1'b1, 1);
      wait_for("t4_wait_req", 2, 2);
      check_eq("t4_req_full", 64'(req_valid[0]), 64'd0);
      redirect[0] = 1'b1; redirect_pc[0] = 32'h0000_0100;
      @(negedge clk);
      redirect[0] = 1'b0;
      check_eq("t4_state", 64'(dut0.state_r), 64'd2);
      wait_for("t4_wait_dec", 0, 1);
      check_eq("t4_dec0", 64'(dec_pc0[0]), 64'h100);
      check_eq("t4_in0", 64'(dec_in0[0]), 64'hDEAD_0100);
      check_eq("t4_req2", 64'(req_q0[2]), 64'h100);

      // Misaligned redirect coinciding with a request handshake and a decode pop.
      do_reset(1, 1'b1, 1);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (req_valid[0] && (req_addr[0] == 32'h8) && if_valid[0]) found = 1'b1;
      end
      check_eq("t5_sync", 64'(found), 64'd1);
      redirect[0] = 1'b1; redirect_pc[0] = 32'h0000_0103;
      @(negedge clk);
      redirect[0] = 1'b0;
      check_eq("t5_flush", 64'(if_valid[0]), 64'd0);
      check_eq("t5_drain", 64'(req_valid[0]), 64'd0);
      wait_for("t5_wait", 0, 3);
      check_eq("t5_dec1", 64'(dec_pc0[1]), 64'h4);
      check_eq("t5_dec2", 64'(dec_pc0[2]), 64'h100);
      check_eq("t5_req2", 64'(req_q0[2]), 64'h8);
      check_eq("t5_req3", 64'(req_q0[3]), 64'h100);

      // PC wrap from 0xFFFF_FFFC and a second redirect while draining.
      do_reset(1, 1'b1, 3);
      wait_for("t6_wait_req", 3, 2);
      check_eq("t6_req0", 64'(req_q1[0]), 64'hFFFF_FFFC);
      check_eq("t6_req1", 64'(req_q1[1]), 64'h0);
      redirect[1] = 1'b1; redirect_pc[1] = 32'h0000_0180;
      @(negedge clk);
      check_eq("t6_state", 64'(dut1.state_r), 64'd2);
      redirect_pc[1] = 32'h0000_0200;
      @(negedge clk);
      redirect[1] = 1'b0;
      wait_for("t6_wait_dec", 1, 1);
      check_eq("t6_dec0", 64'(dec_pc1[0]), 64'h200);
      check_eq("t6_req2", 64'(req_q1[2]), 64'h200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
